// File: rtl/peripheral_oplib_pkg.sv
// Shared types for the front-panel operand loader: FSM states, byte type, sizing helper.
package peripheral_oplib_pkg;

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_READY = 1'b1
  } oplib_state_e;

  typedef logic [7:0] byte_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/peripheral_edge_rise.sv
// Two-flop rising-edge detector; flops preset to 1 so a level held through reset never pulses.
module peripheral_edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic r_q1;
  logic r_q2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q1 <= 1'b1;
      r_q2 <= 1'b1;
    end else begin
      r_q1 <= level;
      r_q2 <= r_q1;
    end
  end

  assign pulse = r_q1 & ~r_q2;

endmodule

// File: rtl/peripheral_operand_loader.sv
// Byte-serial operand entry and result readback for the front panel.
// Optional byte-undo enabled by defining PERIPHERAL_OPLOAD_UNDO_EN.
//
// state   | meaning
// S_LOAD  | collecting operand bytes at wr_ptr
// S_READY | all NB bytes loaded, operands frozen for the core
module peripheral_operand_loader
  import peripheral_oplib_pkg::*;
#(
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 32,
  parameter int RES_W   = 32,
  localparam int NB     = NUM_OPS * OP_W / 8,
  localparam int RB     = RES_W / 8,
  localparam int PW     = $clog2(max_int(NB, RB) + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              inputdata,
  input  logic                    enterpulse,
  input  logic                    loaddata,
  input  logic                    clear,
  input  logic                    undo,
  input  logic [RES_W-1:0]        dataR,
  output logic [NUM_OPS*OP_W-1:0] operands,
  output logic                    inputdata_ready,
  output logic [7:0]              dataoutput,
  output logic [PW-1:0]           pos,
  output logic                    byte_strobe
);

  oplib_state_e r_state, w_state_nxt;
  byte_t        r_bytes [NB];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  byte_t        r_dout;
  logic         r_strobe;

  logic          w_enter, w_undo;
  logic          w_wr, w_rd, w_un;
  logic [PW-1:0] w_wr_idx, w_un_idx;
  byte_t         w_rd_byte;

  peripheral_edge_rise u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .level (enterpulse),
    .pulse (w_enter)
  );

`ifdef PERIPHERAL_OPLOAD_UNDO_EN
  peripheral_edge_rise u_undo_edge (
    .clk   (clk),
    .reset (reset),
    .level (undo),
    .pulse (w_undo)
  );
`else
  logic w_unused_undo;
  assign w_unused_undo = undo;
  assign w_undo        = 1'b0;
`endif

  // A new entry from READY restarts at byte 0; wr_ptr sits at NB there
  assign w_wr_idx = (r_state == S_READY) ? '0 : r_wr_ptr;
  assign w_un_idx = r_wr_ptr - PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_un        = 1'b0;
    if (clear) begin
      w_state_nxt = S_LOAD;
    end else if (w_enter) begin
      if (loaddata) begin
        w_wr        = 1'b1;
        w_state_nxt = (w_wr_idx == PW'(NB - 1)) ? S_READY : S_LOAD;
      end else begin
        w_rd = 1'b1;
      end
    end else if (w_undo && (r_wr_ptr != '0)) begin
      w_un        = 1'b1;
      w_state_nxt = S_LOAD;
    end
  end

  always_comb begin
    w_rd_byte = '0;
    for (int i = 0; i < RB; i++) begin
      if (r_rd_ptr == PW'(i)) w_rd_byte = dataR[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NB; i++) r_bytes[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_wr | w_rd | w_un;
      if (clear) begin
        for (int i = 0; i < NB; i++) r_bytes[i] <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (w_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (w_wr_idx == PW'(i)) r_bytes[i] <= inputdata;
        end
        r_wr_ptr <= w_wr_idx + PW'(1);
        r_dout   <= inputdata;
      end else if (w_rd) begin
        r_dout   <= w_rd_byte;
        r_rd_ptr <= (r_rd_ptr == PW'(RB - 1)) ? '0 : r_rd_ptr + PW'(1);
      end else if (w_un) begin
        for (int i = 0; i < NB; i++) begin
          if (w_un_idx == PW'(i)) r_bytes[i] <= '0;
        end
        r_wr_ptr <= w_un_idx;
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_flat
    assign operands[g*8 +: 8] = r_bytes[g];
  end

  assign inputdata_ready = (r_state == S_READY);
  assign dataoutput      = r_dout;
  assign byte_strobe     = r_strobe;
  assign pos             = loaddata ? r_wr_ptr : r_rd_ptr;

endmodule

// File: tb/tb_peripheral_operand_loader.sv
// Scoreboard bench for peripheral_operand_loader at default parameters; undo
// expectations follow PERIPHERAL_OPLOAD_UNDO_EN when it is defined.
module tb_peripheral_operand_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  inputdata = '0;
  logic        enterpulse = 1'b0;
  logic        loaddata = 1'b1;
  logic        clear = 1'b0;
  logic        undo = 1'b0;
  logic [31:0] dataR = '0;
  logic [63:0] operands;
  logic        inputdata_ready;
  logic [7:0]  dataoutput;
  logic [3:0]  pos;
  logic        byte_strobe;

  peripheral_operand_loader dut (
    .clk             (clk),
    .reset           (reset),
    .inputdata       (inputdata),
    .enterpulse      (enterpulse),
    .loaddata        (loaddata),
    .clear           (clear),
    .undo            (undo),
    .dataR           (dataR),
    .operands        (operands),
    .inputdata_ready (inputdata_ready),
    .dataoutput      (dataoutput),
    .pos             (pos),
    .byte_strobe     (byte_strobe)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_strobes = 0;
  int          m_strobes = 0;
  logic [7:0]  sb_q [$];
  logic [63:0] m_ops = '0;
  int          m_wr = 0;
  int          m_rd = 0;
  bit          m_ready = 1'b0;
  logic [7:0]  m_dout = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && byte_strobe) begin
      n_strobes++;
      if (sb_q.size() == 0) begin
        chk("strobe_unexpected", 1, 0);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("dataoutput", dataoutput, e);
      end
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    sb_q.push_back(b);
    m_strobes++;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_operands"}, operands, m_ops);
    chk({tag, "_ready"}, inputdata_ready, m_ready);
    chk({tag, "_pos"}, pos, loaddata ? m_wr : m_rd);
  endtask

  task automatic settle();
    enterpulse = 1'b0;
    undo       = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
  endtask

  task automatic press(input logic [7:0] d, input bit ld, input bit with_undo);
    int idx;
    @(negedge clk);
    inputdata  = d;
    loaddata   = ld;
    enterpulse = 1'b1;
    undo       = with_undo;
    if (ld) begin
      idx = m_ready ? 0 : m_wr;
      m_ops[idx*8 +: 8] = d;
      m_wr    = idx + 1;
      m_ready = (idx == 7);
      m_dout  = d;
    end else begin
      m_dout = dataR[m_rd*8 +: 8];
      m_rd   = (m_rd + 1) % 4;
    end
    expect_byte(m_dout);
    repeat (2) @(negedge clk);
    settle();
  endtask

  task automatic undo_press();
    @(negedge clk);
    loaddata = 1'b1;
    undo     = 1'b1;
`ifdef PERIPHERAL_OPLOAD_UNDO_EN
    if (m_wr > 0) begin
      m_wr--;
      m_ops[m_wr*8 +: 8] = '0;
      m_ready = 1'b0;
      expect_byte(m_dout);
    end
`endif
    repeat (2) @(negedge clk);
    settle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    m_ops   = '0;
    m_wr    = 0;
    m_rd    = 0;
    m_ready = 1'b0;
    m_dout  = '0;
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_operands", operands, 0);
    chk("rst_ready", inputdata_ready, 0);
    chk("rst_dout", dataoutput, 0);
    chk("rst_strobe", byte_strobe, 0);
    chk("rst_pos", pos, 0);
    reset = 1'b1;
    @(negedge clk);

    // full load with pointer stepping
    for (int i = 1; i <= 8; i++) begin
      press(8'(i * 8'h11), 1'b1, 1'b0);
      chk_state("load");
    end
    chk("load_lo", operands[31:0], 32'h4433_2211);
    chk("load_hi", operands[63:32], 32'h8877_6655);

    // readback walks the result little-endian and wraps
    dataR = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      press(8'h00, 1'b0, 1'b0);
      chk_state("readback");
    end
    loaddata = 1'b1;
    @(negedge clk);
    chk_state("after_rb");

    press(8'hAA, 1'b1, 1'b0);
    chk_state("reentry");

    // undo sequence, including undo at wr_ptr 0
    do_reset();
    press(8'h11, 1'b1, 1'b0);
    press(8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      undo_press();
      chk_state("undo");
    end
    for (int i = 0; i < 8; i++) press(8'(8'hA0 + i), 1'b1, 1'b0);
    undo_press();
    chk_state("undo_ready");

    // clear beats a simultaneous enter pulse
    do_reset();
    press(8'h5A, 1'b1, 1'b0);
    press(8'h6B, 1'b1, 1'b0);
    @(negedge clk);
    inputdata  = 8'hC3;
    loaddata   = 1'b1;
    enterpulse = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    m_ops   = '0;
    m_wr    = 0;
    m_rd    = 0;
    m_ready = 1'b0;
    settle();
    chk_state("clear");
    chk("clear_dout", dataoutput, m_dout);

    // enter and undo edges together: only enter acts
    press(8'h31, 1'b1, 1'b0);
    press(8'h32, 1'b1, 1'b1);
    chk_state("enter_undo");

    // enter held across reset, then released
    @(negedge clk);
    inputdata  = 8'h77;
    loaddata   = 1'b1;
    enterpulse = 1'b1;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    m_ops   = '0;
    m_wr    = 0;
    m_rd    = 0;
    m_ready = 1'b0;
    m_dout  = '0;
    repeat (3) @(negedge clk);
    settle();
    chk_state("held_rst");
    chk("held_rst_dout", dataoutput, 0);

    // reset mid-entry discards partial operand
    press(8'h01, 1'b1, 1'b0);
    press(8'h02, 1'b1, 1'b0);
    press(8'h03, 1'b1, 1'b0);
    do_reset();
    chk_state("mid_rst");

    repeat (2) @(negedge clk);
    chk("sb_final", sb_q.size(), 0);
    chk("strobe_count", n_strobes, m_strobes);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peripheral_operand_loader.md
# peripheral_operand_loader

Parametrised byte-serial operand entry and result readback peripheral for the switch/button front panel. It collects NUM_OPS operands of OP_W bits, one 8-bit switch byte per debounced enter press, and presents them as a packed bus to the arithmetic core. In readback mode it steps through the RES_W-bit core result byte by byte for the display. It generalises the fixed two-operand, 32-bit loader with parametrised counts, a handshake-style ready flag, a clear input, and an optional byte-undo.

## Interface
- NUM_OPS, 2: number of operands; ≥1.
- OP_W, 32: operand width; multiple of 8, ≥8.
- RES_W, 32: result width; multiple of 8, ≥8.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- inputdata  in  8  switch byte.
- enterpulse  in  1  debounced enter button level; only rising edges act.
- loaddata  in  1  1 = load mode, 0 = readback mode; sampled with the enter edge.
- clear  in  1  synchronous operand clear, active-high.
- undo  in  1  debounced backspace button level; functional only with the macro in Configuration.
- dataR  in  RES_W  result from the core.
- operands  out  NUM_OPS*OP_W  operand k at [k*OP_W +: OP_W].
- inputdata_ready  out  1  all operand bytes loaded.
- dataoutput  out  8  display byte.
- pos  out  $clog2(max(NUM_OPS*OP_W/8, RES_W/8)+1)  write pointer in load mode, read pointer in readback mode.
- byte_strobe  out  1  one-cycle pulse on every accepted enter or undo action.

## Operation
- Constants: NB = NUM_OPS*OP_W/8 load bytes. RB = RES_W/8 result bytes.
- Byte order is little-endian. Load byte i goes to operand i/(OP_W/8), byte lane i%(OP_W/8). Lane 0 is the LSB.
- Edge detect: the enter and undo levels are registered twice each. An action pulse is q1 & ~q2. Both edge registers reset to 1, so a button held through reset produces no pulse.
- FSM states:
  - LOAD: an enter pulse with loaddata=1 writes inputdata to byte wr_ptr and increments wr_ptr. Writing byte NB-1 moves the FSM to READY.
  - READY: inputdata_ready=1 and operands are frozen. An enter pulse with loaddata=1 starts a new entry. Byte 0 is overwritten, wr_ptr becomes 1, and the FSM returns to LOAD; bytes 1..NB-1 keep their old values until they are rewritten.
- Readback is available in any state. An enter pulse with loaddata=0 drives dataoutput with dataR byte rd_ptr, then rd_ptr increments and wraps from RB-1 to 0. wr_ptr and the FSM state are unchanged.
- In load mode, dataoutput echoes the written byte.
- pos shows wr_ptr when loaddata=1 and rd_ptr when loaddata=0. It is combinational from the registered pointers.
- clear=1: all operand bytes, wr_ptr and rd_ptr go to 0, the FSM goes to LOAD, and dataoutput is unchanged. In the same cycle, clear takes priority over enter and undo.
- An enter pulse and an undo pulse in the same cycle: enter wins, and the undo is dropped.

## Timing
- Reset (reset=0 at an edge): operands=0, inputdata_ready=0, dataoutput=0, byte_strobe=0, wr_ptr=0, rd_ptr=0, FSM=LOAD.
- Reset mid-entry discards the partial operand.
- Enter first sampled high at edge k: the pulse is active in cycle k. The write or readback happens at edge k+1, and inputdata, loaddata and dataR are sampled at edge k+1.
- byte_strobe is high for the cycle after edge k+1.
- inputdata_ready rises at the same edge as the write of byte NB-1. It falls at the edge of the first write of a new entry or of a clear.
- operands are valid for the core whenever inputdata_ready=1.
- One action per button press, independent of hold time.

## Configuration
- PERIPHERAL_OPLOAD_UNDO_EN defined:
  - In LOAD with wr_ptr>0, an undo pulse decrements wr_ptr and zeroes that byte.
  - In READY, undo zeroes byte NB-1, sets wr_ptr=NB-1 and returns the FSM to LOAD, so inputdata_ready falls.
  - In LOAD with wr_ptr=0, undo does nothing, and byte_strobe does not pulse.
- PERIPHERAL_OPLOAD_UNDO_EN undefined: the undo port exists but is ignored, and no undo edge registers are synthesised.

## Structure
- Package peripheral_oplib_pkg holds the FSM state enum (S_LOAD, S_READY) and a byte_t typedef (logic [7:0]).
- Sub-module peripheral_edge_rise (clk, reset, level → pulse): two-flop rising-edge detector with preset-to-1 reset. It is instantiated for enter, and for undo when the macro is defined.
- Operand storage is a byte array of NB entries, flattened onto operands.

## Test plan
All scenarios use the defaults (2×32-bit operands, 32-bit result).
- Enter 0x11,0x22,…,0x88 with loaddata=1 → operands[31:0]=0x44332211 and operands[63:32]=0x88776655. inputdata_ready rises with the 8th press, and pos steps 0→8.
- dataR=0xDEADBEEF, 5 presses with loaddata=0 → dataoutput EF, BE, AD, DE, EF, with pos wrapping 0→3→0. wr_ptr and inputdata_ready are unchanged.
- After a full load, press enter with 0xAA → inputdata_ready=0, operands[7:0]=0xAA and pos=1. The other bytes are retained.
- Hold enter across a reset pulse, then release → no write occurs. Reset during byte 3 → operands=0 and pos=0.
- clear asserted in the same cycle as an enter pulse → no write, and operands=0. Enter and undo edges in the same cycle → only the enter acts.
- With the undo macro, load 0x11,0x22, then undo → operands[15:8]=0 and pos=1. Undo again twice → pos=0 and no strobe on the second undo.
